// File: rtl/profcounter_dump_ctrl.sv
// profcounter_dump_ctrl
//   Dumps a snapshot of NUM_COUNTERS 64-bit profiling counters through the
//   SequentialWriter command port. An accepted start latches the target
//   offset and snapshots every counter. The block then issues an optional
//   header PUSH, one PUSH per counter and a FLUSH. It ignores wrIdle for a
//   short guard window, waits for the writer to go idle and pulses done.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : dump request, level-sampled every cycle
//   baseAddr   : target offset, latched when a dump is accepted
//   counters   : counter i at [64*i+63:64*i], snapshotted at accept
//   busy       : high from accept until done
//   done       : one-cycle completion pulse
//   dumpCount  : number of completed dumps (wraps)
//   overrun    : sticky, start seen while a dump was in progress
//   wrOffset   : writer offset, held from one accept to the next
//   wrCommand  : writer command (0 NOP, 1 PUSH, 2 FLUSH)
//   wrValue    : writer value, zero whenever wrCommand is NOP
//   wrIdle     : writer idle flag

module profcounter_dump_ctrl #(
    parameter int NUM_COUNTERS = 4,
    parameter bit HEADER_EN    = 1'b1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [63:0]                baseAddr,
    input  logic [64*NUM_COUNTERS-1:0] counters,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                dumpCount,
    output logic                       overrun,
    output logic [63:0]                wrOffset,
    output logic [3:0]                 wrCommand,
    output logic [63:0]                wrValue,
    input  logic                       wrIdle
);

    localparam int          GW       = $clog2(GUARD_CYCLES + 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_COUNTERS - 1);
    localparam logic [15:0] NUM_W16  = 16'(NUM_COUNTERS);
    localparam logic [3:0]  CMD_NOP   = 4'd0;
    localparam logic [3:0]  CMD_PUSH  = 4'd1;
    localparam logic [3:0]  CMD_FLUSH = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PUSH  = 3'd2,
        S_FLUSH = 3'd3,
        S_GUARD = 3'd4,
        S_WAITI = 3'd5
    } state_e;

    state_e                     state_q;
    logic                       pending_q;
    logic [64*NUM_COUNTERS-1:0] snap_q;
    logic [7:0]                 idx_q;
    logic [GW-1:0]              guard_q;
    logic                       busy_q;
    logic                       done_q;
    logic [31:0]                dump_count_q;
    logic                       overrun_q;
    logic [63:0]                wr_offset_q;
    logic [3:0]                 wr_command_q;
    logic [63:0]                wr_value_q;

    logic                       accept_s;
    logic [63:0]                push_word_s;

    // A pending request counts the same as a live start, so a request made
    // while the writer is still busy is never lost.
    assign accept_s = (state_q == S_IDLE) && (start || pending_q) && wrIdle;

    // Select the snapshot word addressed by idx_q using constant slices only.
    always_comb begin
        push_word_s = 64'd0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            push_word_s = (idx_q == 8'(i)) ? snap_q[64*i +: 64] : push_word_s;
        end
    end

    // Dump sequencer: state, snapshot and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            snap_q       <= '0;
            idx_q        <= 8'd0;
            guard_q      <= {GW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dump_count_q <= 32'd0;
            overrun_q    <= 1'b0;
            wr_offset_q  <= 64'd0;
            wr_command_q <= CMD_NOP;
            wr_value_q   <= 64'd0;
        end else begin
            // Commands and done are single-cycle; they fall back by default.
            wr_command_q <= CMD_NOP;
            wr_value_q   <= 64'd0;
            done_q       <= 1'b0;

            // Any start outside IDLE is dropped and flagged; this includes
            // the WAITI cycle in which done is produced.
            if (start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        wr_offset_q <= baseAddr;
                        snap_q      <= counters;
                        busy_q      <= 1'b1;
                        pending_q   <= 1'b0;
                        idx_q       <= 8'd0;
                        state_q     <= HEADER_EN ? S_HDR : S_PUSH;
                    end else if (start) begin
                        pending_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    // Header carries the pre-increment dump count.
                    wr_command_q <= CMD_PUSH;
                    wr_value_q   <= {16'hC0DE, NUM_W16, dump_count_q};
                    idx_q        <= 8'd0;
                    state_q      <= S_PUSH;
                end
                S_PUSH: begin
                    wr_command_q <= CMD_PUSH;
                    wr_value_q   <= push_word_s;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_FLUSH;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                S_FLUSH: begin
                    wr_command_q <= CMD_FLUSH;
                    guard_q      <= GW'(GUARD_CYCLES);
                    state_q      <= S_GUARD;
                end
                S_GUARD: begin
                    // The writer may still report idle right after FLUSH;
                    // its flag is not trusted until the guard expires.
                    if (guard_q == {GW{1'b0}}) begin
                        state_q <= S_WAITI;
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end
                S_WAITI: begin
                    if (wrIdle) begin
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        dump_count_q <= dump_count_q + 32'd1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dumpCount = dump_count_q;
    assign overrun   = overrun_q;
    assign wrOffset  = wr_offset_q;
    assign wrCommand = wr_command_q;
    assign wrValue   = wr_value_q;

endmodule

// File: tb/tb_profcounter_dump_ctrl.sv
// tb_profcounter_dump_ctrl
//   Scoreboard bench for profcounter_dump_ctrl. Every dump the bench starts
//   pushes its expected writer words, with the cycle each must appear on,
//   into a queue. A negedge monitor pops and compares each issued command.
//   Directed sequences cover reset, waiting for writer idle, counter changes
//   during a dump, overrun and reset in the middle of a dump.

module tb_profcounter_dump_ctrl;

    localparam int N = 4;
    localparam int G = 2;

    typedef struct {
        logic [3:0]  cmd;
        logic [63:0] val;
        int          at;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [63:0]        baseAddr;
    logic [64*N-1:0]    counters;
    logic               busy;
    logic               done;
    logic [31:0]        dumpCount;
    logic               overrun;
    logic [63:0]        wrOffset;
    logic [3:0]         wrCommand;
    logic [63:0]        wrValue;
    logic               wrIdle;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          done_pulses;
    int          exp_pulses;
    logic [31:0] exp_count;

    profcounter_dump_ctrl #(
        .NUM_COUNTERS (N),
        .HEADER_EN    (1'b1),
        .GUARD_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .baseAddr  (baseAddr),
        .counters  (counters),
        .busy      (busy),
        .done      (done),
        .dumpCount (dumpCount),
        .overrun   (overrun),
        .wrOffset  (wrOffset),
        .wrCommand (wrCommand),
        .wrValue   (wrValue),
        .wrIdle    (wrIdle)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp expected writer words.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [64*N-1:0] rand_counters();
        logic [64*N-1:0] r;
        for (int i = 0; i < N; i++) r[64*i +: 64] = {$urandom(), $urandom()};
        return r;
    endfunction

    // Expected writer words for a dump whose start/wrIdle conditions first
    // hold at the negedge where cyc == base_cyc (accept edge is base_cyc+1).
    task automatic expect_dump(input int base_cyc, input logic [64*N-1:0] snap);
        exp_t e;
        e.cmd = 4'd1;
        e.val = {16'hC0DE, 16'(N), exp_count};
        e.at  = base_cyc + 2;
        sb.push_back(e);
        for (int i = 0; i < N; i++) begin
            e.cmd = 4'd1;
            e.val = snap[64*i +: 64];
            e.at  = base_cyc + 3 + i;
            sb.push_back(e);
        end
        e.cmd = 4'd2;
        e.val = 64'd0;
        e.at  = base_cyc + 3 + N;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int max_cycles, input bit scramble, output int done_cyc);
        done_cyc = -1;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (scramble) counters = rand_counters();
        end
        check_val("done_seen", done, 1'b1);
    endtask

    // Checks made at the done cycle; returns one negedge later.
    task automatic finish_dump(input int dc, input int exp_dc, input logic [63:0] exp_off);
        check_val("done_cycle", dc, exp_dc);
        exp_count++;
        exp_pulses++;
        check_val("busy_at_done", busy, 1'b0);
        check_val("dump_count", dumpCount, exp_count);
        check_val("wr_offset", wrOffset, exp_off);
        @(negedge clk);
        check_val("done_one_cycle", done, 1'b0);
    endtask

    // Scoreboard monitor: every issued command must match the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) done_pulses++;
        if (wrCommand != 4'd0) begin
            if (sb.size() == 0) begin
                check_val("unexpected_cmd", wrCommand, 4'd0);
            end else begin
                e = sb.pop_front();
                check_val("cmd", wrCommand, e.cmd);
                check_val("value", wrValue, e.val);
                check_val("cmd_cycle", cyc, e.at);
            end
        end else begin
            check_val("nop_value", wrValue, 64'd0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int c;
        int f;
        int dc;
        logic [64*N-1:0] snap;

        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        done_pulses = 0;
        exp_pulses  = 0;
        exp_count   = 32'd0;
        rst_n       = 1'b0;
        start       = 1'b1;
        wrIdle      = 1'b1;
        baseAddr    = 64'h1234;
        counters    = '0;

        // 1: reset with start held high
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_dump_count", dumpCount, 32'd0);
        check_val("rst_overrun", overrun, 1'b0);
        check_val("rst_wr_offset", wrOffset, 64'd0);
        check_val("rst_wr_command", wrCommand, 4'd0);
        check_val("rst_wr_value", wrValue, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_busy", busy, 1'b0);

        // 2: basic dump, writer drops idle for 5 cycles after FLUSH
        counters = {64'd40, 64'd30, 64'd20, 64'd10};
        baseAddr = 64'hDEADCAFE00;
        start    = 1'b1;
        b        = cyc;
        expect_dump(b, counters);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_accept", busy, 1'b1);
        while (cyc < b + 3 + N) @(negedge clk);
        f = cyc;
        wrIdle = 1'b0;
        repeat (5) @(negedge clk);
        check_val("busy_waiting_idle", busy, 1'b1);
        wrIdle = 1'b1;
        wait_done(20, 1'b0, dc);
        finish_dump(dc, f + 6, 64'hDEADCAFE00);
        repeat (3) @(negedge clk);
        check_val("done_pulse_count", done_pulses, exp_pulses);

        // 3: start pulse while writer busy; dump begins once idle returns
        counters = rand_counters();
        baseAddr = 64'h0000_0100_0000_0040;
        wrIdle   = 1'b0;
        start    = 1'b1;
        c        = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        check_val("pending_not_busy", busy, 1'b0);
        wrIdle = 1'b1;
        expect_dump(c + 10, counters);
        wait_done(40, 1'b0, dc);
        finish_dump(dc, c + 10 + N + G + 5, 64'h0000_0100_0000_0040);

        // 4: counters scrambled every cycle during the dump
        snap     = rand_counters();
        counters = snap;
        baseAddr = 64'hFFFF_FFFF_FFFF_FFF8;
        start    = 1'b1;
        b        = cyc;
        expect_dump(b, snap);
        @(negedge clk);
        start    = 1'b0;
        counters = rand_counters();
        wait_done(40, 1'b1, dc);
        finish_dump(dc, b + N + G + 5, 64'hFFFF_FFFF_FFFF_FFF8);
        check_val("no_overrun", overrun, 1'b0);

        // 5: start held through a dump -> overrun, back-to-back restart
        snap     = rand_counters();
        counters = snap;
        baseAddr = 64'h55AA;
        start    = 1'b1;
        b        = cyc;
        expect_dump(b, snap);
        wait_done(40, 1'b0, dc);
        finish_dump(dc, b + N + G + 5, 64'h55AA);
        expect_dump(dc, snap);
        start = 1'b0;
        check_val("overrun_set", overrun, 1'b1);
        check_val("restart_busy", busy, 1'b1);
        b = dc;
        wait_done(40, 1'b0, dc);
        finish_dump(dc, b + N + G + 5, 64'h55AA);
        check_val("overrun_sticky", overrun, 1'b1);

        // 6: reset while in PUSH with idx=2
        snap     = rand_counters();
        counters = snap;
        baseAddr = 64'h7777;
        start    = 1'b1;
        b        = cyc;
        expect_dump(b, snap);
        @(negedge clk);
        start = 1'b0;
        while (cyc < b + 4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_wr_command", wrCommand, 4'd0);
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_dump_count", dumpCount, 32'd0);
        check_val("midrst_overrun", overrun, 1'b0);
        sb.delete();
        exp_count = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap     = rand_counters();
        counters = snap;
        baseAddr = 64'h8888;
        start    = 1'b1;
        b        = cyc;
        expect_dump(b, snap);
        @(negedge clk);
        start = 1'b0;
        wait_done(40, 1'b0, dc);
        finish_dump(dc, b + N + G + 5, 64'h8888);

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        check_val("done_pulse_total", done_pulses, exp_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
